// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3 memory-backed slave with independent write and read FSMs
// sharing one word-addressed array. FIXED/INCR/WRAP bursts, byte strobes, SLVERR.
// Optional: define AXI_SLV_WID_CHECK_EN to compare wid with the latched awid on every W beat.
module axi_slave_mem #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  // Whole-burst errors: reserved burst, oversize beat, or malformed WRAP.
  function automatic logic cmd_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic len_ok;
    logic aligned;
    len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    aligned = (addr & ((ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1))) == '0;
    cmd_err = (burst == BURST_RSVD) || (size > 3'(LSB)) || ((burst == BURST_WRAP) && !(len_ok && aligned));
  endfunction

  // Address of the following beat; WRAP stays inside the (len+1)*2^size window.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                                      input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:     next_addr = addr + step;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  wstate_e               r_wstate, w_wstate_nxt;
  logic [ID_WIDTH-1:0]   r_wid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic [8:0]            r_wcnt;
  logic                  r_wcmd_err, r_werr;
  logic                  w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
  logic                  w_aw_hs, w_w_hs, w_w_final;
  logic [ADDR_WIDTH-1:0] w_wword;
  logic                  w_wid_bad, w_wbeat_err, w_wlast_err, w_mem_we, w_aw_cmd_err;
  logic                  w_unused;

  rstate_e               r_rstate, w_rstate_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rlen, r_rbeat;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic                  r_rcmd_err;
  logic                  w_arready_nxt, w_ar_hs, w_r_adv, w_r_done;
  logic [ADDR_WIDTH-1:0] w_rf_addr, w_rf_word;
  logic                  w_rf_err, w_ar_cmd_err;

`ifdef AXI_SLV_WID_CHECK_EN
  assign w_wid_bad = (wid != r_wid);
`else
  assign w_wid_bad = 1'b0;
`endif
  assign w_unused     = ^wid;
  assign w_aw_cmd_err = cmd_err(awaddr, awlen, awsize, awburst);
  assign w_wword      = r_waddr >> LSB;
  assign w_wbeat_err  = r_wcmd_err || (w_wword >= ADDR_WIDTH'(MEM_DEPTH)) || w_wid_bad;
  assign w_wlast_err  = (wlast != (r_wcnt == 9'd1));
  assign w_mem_we     = w_w_hs && !w_wbeat_err;

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state and next handshake outputs.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_bvalid_nxt  = 1'b0;
    w_aw_hs       = 1'b0;
    w_w_hs        = 1'b0;
    w_w_final     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready_nxt = 1'b1;
        if (awvalid && awready) begin
          w_aw_hs       = 1'b1;
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b1;
          w_wstate_nxt  = W_DATA;
        end
      end
      W_DATA: begin
        w_wready_nxt = 1'b1;
        if (wvalid && wready) begin
          w_w_hs = 1'b1;
          if (r_wcnt == 9'd1) begin
            w_w_final    = 1'b1;
            w_wready_nxt = 1'b0;
            w_bvalid_nxt = 1'b1;
            w_wstate_nxt = W_RESP;
          end
        end
      end
      W_RESP: begin
        w_bvalid_nxt = 1'b1;
        if (bvalid && bready) begin
          w_bvalid_nxt = 1'b0;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write command capture, beat accounting and B channel registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
      bid <= '0; bresp <= RESP_OKAY;
      r_wid <= '0; r_waddr <= '0; r_wlen <= '0; r_wsize <= '0; r_wburst <= '0;
      r_wcnt <= '0; r_wcmd_err <= 1'b0; r_werr <= 1'b0;
    end else begin
      awready <= w_awready_nxt;
      wready  <= w_wready_nxt;
      bvalid  <= w_bvalid_nxt;
      if (w_aw_hs) begin
        r_wid <= awid; r_waddr <= awaddr; r_wlen <= awlen; r_wsize <= awsize; r_wburst <= awburst;
        r_wcnt     <= 9'(awlen) + 9'd1;
        r_wcmd_err <= w_aw_cmd_err;
        r_werr     <= w_aw_cmd_err;
      end
      if (w_w_hs) begin
        r_waddr <= next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
        r_wcnt  <= r_wcnt - 9'd1;
        r_werr  <= r_werr || w_wbeat_err || w_wlast_err;
      end
      if (w_w_final) begin
        bid   <= r_wid;
        bresp <= (r_werr || w_wbeat_err || w_wlast_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Byte-strobed memory write; contents survive reset.
  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) r_mem[w_wword[IDX_W-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Fetch address is the AR address on acceptance, else the successor of the presented beat.
  assign w_ar_cmd_err = cmd_err(araddr, arlen, arsize, arburst);
  assign w_rf_addr    = (r_rstate == R_IDLE) ? araddr : next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
  assign w_rf_word    = w_rf_addr >> LSB;
  assign w_rf_err     = ((r_rstate == R_IDLE) ? w_ar_cmd_err : r_rcmd_err) || (w_rf_word >= ADDR_WIDTH'(MEM_DEPTH));

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state and beat sequencing strobes.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = 1'b0;
    w_ar_hs       = 1'b0;
    w_r_adv       = 1'b0;
    w_r_done      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready_nxt = 1'b1;
        if (arvalid && arready) begin
          w_ar_hs       = 1'b1;
          w_arready_nxt = 1'b0;
          w_rstate_nxt  = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid && rready) begin
          if (rlast) begin
            w_r_done     = 1'b1;
            w_rstate_nxt = R_IDLE;
          end else begin
            w_r_adv = 1'b1;
          end
        end
      end
    endcase
  end

  // R channel registers; a registered array read returns pre-write data on a same-cycle collision.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0;
      rid <= '0; rdata <= '0; rresp <= RESP_OKAY;
      r_raddr <= '0; r_rlen <= '0; r_rbeat <= '0; r_rsize <= '0; r_rburst <= '0; r_rcmd_err <= 1'b0;
    end else begin
      arready <= w_arready_nxt;
      if (w_ar_hs || w_r_adv) begin
        r_raddr <= w_rf_addr;
        rvalid  <= 1'b1;
        rresp   <= w_rf_err ? RESP_SLVERR : RESP_OKAY;
        rdata   <= w_rf_err ? '0 : r_mem[w_rf_word[IDX_W-1:0]];
      end
      if (w_ar_hs) begin
        rid <= arid; r_rlen <= arlen; r_rsize <= arsize; r_rburst <= arburst;
        r_rcmd_err <= w_ar_cmd_err;
        r_rbeat    <= '0;
        rlast      <= (arlen == 8'd0);
      end
      if (w_r_adv) begin
        r_rbeat <= r_rbeat + 8'd1;
        rlast   <= ((r_rbeat + 8'd1) == r_rlen);
      end
      if (w_r_done) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Synthesizable AXI3-style memory-backed slave (responder) that answers a master on all five channels: AW, W, B, AR and R.
- Serves as the DUT-side endpoint for the master agent and as a reference slave in loopback environments.
- Write and read paths are independent FSMs sharing one word-addressed memory array.
- Supports FIXED, INCR and WRAP bursts, byte strobes, and SLVERR reporting.

Parameters:
- ID_WIDTH, 4, width of awid/wid/bid/arid/rid.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data bus width; legal values are 32 or 64.
- MEM_DEPTH, 1024, memory size in DATA_WIDTH words; legal byte range is 0 .. MEM_DEPTH*DATA_WIDTH/8-1.

Ports:
- aclk  in  1  clock; all logic on posedge.
- aresetn  in  1  asynchronous active-low reset.
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address.
- awvalid in 1, awready out 1  AW handshake.
- wid  in  ID_WIDTH  write data ID.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- wlast  in  1  last write beat.
- wvalid in 1, wready out 1  W handshake.
- bid  out  ID_WIDTH  response ID.
- bresp  out  2  write response.
- bvalid out 1, bready in 1  B handshake.
- arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address.
- arvalid in 1, arready out 1  AR handshake.
- rid  out  ID_WIDTH  read data ID.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rlast  out  1  last read beat.
- rvalid out 1, rready in 1  R handshake.

Behaviour:
- Reset: all outputs are 0, including awready and arready. Both FSMs enter IDLE. Memory contents are not cleared.
- awready and arready rise on the first posedge after aresetn deasserts.
- Reset asserted mid-burst abandons the burst immediately. Memory writes already performed are kept.
- All outputs are registered.
- Write FSM, W_IDLE:
  - awready=1.
  - On awvalid&&awready: latch id, addr, len, size and burst; beat count = awlen+1; awready->0; go W_DATA.
- Write FSM, W_DATA:
  - wready=1.
  - Each wvalid&&wready beat writes the bytes enabled by wstrb to word addr>>log2(DATA_WIDTH/8), then advances addr and decrements the count.
  - On the final counted beat: wready->0, bvalid->1, bid=latched awid; go W_RESP.
- Write FSM, W_RESP:
  - Hold bid/bresp/bvalid stable until bready.
  - On bvalid&&bready: bvalid->0; go W_IDLE. awready rises the next cycle.
- Read FSM, R_IDLE:
  - arready=1.
  - On arvalid&&arready: latch the command; arready->0; go R_DATA.
  - Beat 0 appears with rvalid=1 on the cycle after the AR handshake.
- Read FSM, R_DATA:
  - rid/rdata/rresp/rlast are held stable while rvalid&&!rready.
  - On each handshake the next beat is presented the following cycle; back-to-back beats are allowed.
  - rlast=1 only on beat arlen.
  - Handshake on the last beat: rvalid->0; go R_IDLE.
- Address update:
  - FIXED: addr unchanged.
  - INCR: addr += 2^size.
  - WRAP: addr += 2^size, wrapping within an aligned window of (len+1)*2^size bytes.
  - WRAP is legal only for len 1, 3, 7 or 15 with an aligned start address.
  - The wrap boundary uses ADDR_WIDTH-bit arithmetic; carries out of the MSB are discarded.
- Error rules (SLVERR = 2'b10):
  - burst==2'b11, size>log2(DATA_WIDTH/8), or an illegal WRAP: whole burst is in error. No memory writes. Every R beat returns rresp=SLVERR and rdata=0. The beat count is still honoured.
  - Out-of-range beat address: write beat is suppressed and bresp=SLVERR; read beat returns SLVERR with rdata=0. Other beats proceed with OKAY.
  - wlast mismatch (asserted early or missing on the final beat): bresp=SLVERR. The beat count, not wlast, ends the burst.
  - Otherwise the response is OKAY (2'b00).
- Simultaneous write beat and read fetch of the same word in one cycle: the read returns the old data.

Optional Feature:
- Macro: AXI_SLV_WID_CHECK_EN.
- Defined: every W beat compares wid to the latched awid; any mismatch forces bresp=SLVERR and suppresses that beat's write.
- Undefined: wid is ignored entirely.

Test Plan:
- Single write then read: INCR, awaddr=0x10, len=0, size=2, wdata=0xDEADBEEF, wstrb=0xF -> bresp=OKAY, bid=awid. A read of 0x10 returns 0xDEADBEEF with rlast=1 on the cycle after the AR handshake.
- INCR burst with partial strobes: len=3 at 0x100, data 0x11111111..0x44444444, beat-2 wstrb=0x3 over prior 0xFFFFFFFF -> readback 0x11111111, 0x22222222, 0xFFFF3333, 0x44444444.
- WRAP len=3, size=2, start 0x08 -> beats land on 0x08, 0x0C, 0x00, 0x04. An INCR read from 0x00 returns them reordered correctly.
- Error paths:
  - awburst=2'b11 -> bresp=SLVERR, memory unchanged.
  - Read at byte address MEM_DEPTH*4 -> rresp=SLVERR, rdata=0.
  - wlast early on beat 1 of len=3 -> bresp=SLVERR after 4 beats.
- Backpressure: rready toggled 1-0-1 over an 8-beat read and bready held low 5 cycles -> outputs held stable, no beat lost or duplicated. aresetn pulsed during beat 3 of a burst -> all outputs are 0 and awready/arready rise after release.
